// File: rtl/key_event_arbiter.sv
// Key event arbiter: turns debounced key levels into press / release /
// long-press events, then schedules them round-robin into a small show-ahead
// FIFO that drives a valid/ready event channel.
module key_event_arbiter #(
    parameter int NUM_KEYS          = 4,
    parameter int KEY_W             = 2,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int CNT_W             = 26,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_db,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_key,
    output logic [1:0]          evt_type,
    output logic                overflow,
    input  logic                clr_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;

    localparam logic [CNT_W-1:0] LONG_LAST     = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // Per-key state
    logic [NUM_KEYS-1:0]            key_prev_q;
    logic [NUM_KEYS-1:0]            press_pend_q, press_pend_d;
    logic [NUM_KEYS-1:0]            rel_pend_q,   rel_pend_d;
    logic [NUM_KEYS-1:0]            long_pend_q,  long_pend_d;
    logic [NUM_KEYS-1:0]            long_done_q,  long_done_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0] hold_cnt_q,   hold_cnt_d;

    // Arbiter and FIFO state
    logic [KEY_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [FIFO_DEPTH-1:0][KEY_W+1:0]   fifo_mem_q;
    logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]                     fifo_cnt_q, fifo_cnt_d;
    logic                               overflow_q, overflow_d;

    // Combinational helpers
    logic [NUM_KEYS-1:0] rise, fall, long_fire, has_work;
    logic [NUM_KEYS-1:0] press_clr, rel_clr, long_clr;
    logic [KEY_W-1:0]    scan_idx;
    logic [KEY_W-1:0]    grant_idx;
    logic                grant_found;
    logic [1:0]          grant_type;
    logic                fifo_full, fifo_empty, fifo_pop, fifo_accept, fifo_push;
    logic                drop;
    logic [KEY_W+1:0]    fifo_head;

    assign rise     = key_db & ~key_prev_q;
    assign fall     = ~key_db & key_prev_q;
    assign has_work = press_pend_q | rel_pend_q | long_pend_q;

    assign fifo_full   = (fifo_cnt_q == FIFO_FULL_CNT);
    assign fifo_empty  = (fifo_cnt_q == '0);
    assign evt_valid   = ~fifo_empty;
    assign fifo_pop    = evt_valid & evt_ready;
    assign fifo_accept = ~fifo_full | fifo_pop;
    assign fifo_push   = grant_found & fifo_accept;

    // Long-press detect: fires once when the hold counter reaches its last count
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            long_fire[i] = key_db[i] & ~long_done_q[i] & (hold_cnt_q[i] == LONG_LAST);
        end
    end

    // Round-robin search from rr_ptr; pick press > long > release within the winner
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the ifs below can leave a value unassigned and infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        grant_type  = EVT_PRESS;
        press_clr   = '0;
        rel_clr     = '0;
        long_clr    = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            scan_idx = KEY_W'((int'(rr_ptr_q) + k) % NUM_KEYS);
            if (!grant_found && has_work[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        if (fifo_push) begin
            if (press_pend_q[grant_idx]) begin
                grant_type           = EVT_PRESS;
                press_clr[grant_idx] = 1'b1;
            end else if (long_pend_q[grant_idx]) begin
                grant_type          = EVT_LONG;
                long_clr[grant_idx] = 1'b1;
            end else begin
                grant_type         = EVT_RELEASE;
                rel_clr[grant_idx] = 1'b1;
            end
        end
    end

    // Next-state for pending bits, hold counters, overflow, pointers
    always_comb begin
        // A new event beats a same-cycle clear, so it is never lost that way
        press_pend_d = (press_pend_q & ~press_clr) | rise;
        rel_pend_d   = (rel_pend_q   & ~rel_clr)   | fall;
        long_pend_d  = (long_pend_q  & ~long_clr)  | long_fire;

        // An event collides only with a pending bit that is staying set
        drop = (|(rise      & press_pend_q & ~press_clr)) |
               (|(fall      & rel_pend_q   & ~rel_clr))   |
               (|(long_fire & long_pend_q  & ~long_clr));

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!key_db[i] || rise[i]) begin
                hold_cnt_d[i] = '0;
            end else if (!long_done_q[i]) begin
                hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
            end else begin
                hold_cnt_d[i] = hold_cnt_q[i];
            end
        end
        long_done_d = key_db & (long_done_q | long_fire);

        if (fifo_push) begin
            rr_ptr_d = (grant_idx == KEY_W'(NUM_KEYS - 1)) ? '0 : grant_idx + KEY_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        wr_ptr_d   = fifo_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = fifo_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + {{PTR_W{1'b0}}, fifo_push} - {{PTR_W{1'b0}}, fifo_pop};
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values;
        // blocking = here would let later statements see already-updated state.
        if (rst) begin
            key_prev_q   <= '0;
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            long_pend_q  <= '0;
            long_done_q  <= '0;
            hold_cnt_q   <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            key_prev_q   <= key_db;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            long_pend_q  <= long_pend_d;
            long_done_q  <= long_done_d;
            hold_cnt_q   <= hold_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage: entry is {key index, event type}
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the count/pointers define which
        // entries are live, and the head is masked while the FIFO is empty.
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= {grant_idx, grant_type};
        end
    end

    assign fifo_head = fifo_mem_q[rd_ptr_q];
    assign evt_key   = fifo_empty ? '0 : fifo_head[KEY_W+1:2];
    assign evt_type  = fifo_empty ? '0 : fifo_head[1:0];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with short long-press time and 2-deep FIFO.
module tb_key_event_arbiter;

    localparam logic [1:0] T_PRESS = 2'b00;
    localparam logic [1:0] T_REL   = 2'b01;
    localparam logic [1:0] T_LONG  = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_db;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic       overflow;
    logic       clr_overflow;

    int checks = 0;
    int errors = 0;
    int waited;

    key_event_arbiter #(
        .NUM_KEYS         (4),
        .KEY_W            (2),
        .LONG_PRESS_CYCLES(8),
        .CNT_W            (4),
        .FIFO_DEPTH       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_db      (key_db),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_key     (evt_key),
        .evt_type    (evt_type),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with evt_ready=1: waits (bounded) for the head, checks it,
    // then steps past the popping posedge to the next negedge.
    task automatic expect_evt(input logic [1:0] k, input logic [1:0] t, input string tag,
                              output int n);
        n = 0;
        while (evt_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, evt_valid, 1);
        check({tag, "_key"},   evt_key,   k);
        check({tag, "_type"},  evt_type,  t);
        @(negedge clk);
    endtask

    // Counts cycles with a valid event over a window; none are expected.
    task automatic expect_quiet(input int cycles, input string tag);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (evt_valid === 1'b1) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        rst          = 1'b1;
        key_db       = 4'b0000;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        #2;
        check("rst_valid",    evt_valid, 0);
        check("rst_key",      evt_key,   0);
        check("rst_type",     evt_type,  0);
        check("rst_overflow", overflow,  0);
        @(negedge clk);
        rst       = 1'b0;
        evt_ready = 1'b1;
        @(negedge clk);

        // Simultaneous presses on all keys, rr_ptr=0: order 0,1,2,3 back to back
        key_db = 4'b1111;
        expect_evt(2'd0, T_PRESS, "sim_p0", waited);
        expect_evt(2'd1, T_PRESS, "sim_p1", waited);
        check("sim_p1_consecutive", waited, 0);
        expect_evt(2'd2, T_PRESS, "sim_p2", waited);
        check("sim_p2_consecutive", waited, 0);
        expect_evt(2'd3, T_PRESS, "sim_p3", waited);
        check("sim_p3_consecutive", waited, 0);
        check("sim_rr_after", dut.rr_ptr_q, 0);
        key_db = 4'b0000;
        expect_evt(2'd0, T_REL, "sim_r0", waited);
        expect_evt(2'd1, T_REL, "sim_r1", waited);
        expect_evt(2'd2, T_REL, "sim_r2", waited);
        expect_evt(2'd3, T_REL, "sim_r3", waited);
        check("sim_overflow", overflow, 0);

        // Backpressure: 2-deep FIFO fills with keys 0,1; key 3 re-press is dropped
        evt_ready = 1'b0;
        key_db    = 4'b1111;
        repeat (3) @(negedge clk);
        key_db = 4'b0111;
        @(negedge clk);
        key_db = 4'b1111;
        @(negedge clk);
        check("bp_overflow_set", overflow,  1);
        check("bp_head_valid",   evt_valid, 1);
        check("bp_head_key",     evt_key,   0);
        check("bp_head_type",    evt_type,  T_PRESS);
        check("bp_fifo_full",    dut.fifo_cnt_q, 2);
        key_db = 4'b0000;
        repeat (2) @(negedge clk);
        check("bp_still_full", dut.fifo_cnt_q, 2);
        evt_ready = 1'b1;
        expect_evt(2'd0, T_PRESS, "bp_e0", waited);
        check("bp_full_rw_count", dut.fifo_cnt_q, 2);
        expect_evt(2'd1, T_PRESS, "bp_e1", waited);
        check("bp_e1_consecutive", waited, 0);
        expect_evt(2'd2, T_PRESS, "bp_e2", waited);
        check("bp_e2_consecutive", waited, 0);
        expect_evt(2'd3, T_PRESS, "bp_e3", waited);
        check("bp_e3_consecutive", waited, 0);
        expect_evt(2'd0, T_REL, "bp_e4", waited);
        expect_evt(2'd1, T_REL, "bp_e5", waited);
        expect_evt(2'd2, T_REL, "bp_e6", waited);
        expect_evt(2'd3, T_REL, "bp_e7", waited);
        expect_quiet(6, "bp_no_extra");
        check("bp_overflow_held", overflow, 1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("bp_overflow_cleared", overflow, 0);

        // Single tap on key 2 for 3 cycles: press visible 2 edges after rise
        key_db = 4'b0100;
        @(negedge clk);
        check("tap_lat1_valid", evt_valid, 0);
        @(negedge clk);
        check("tap_lat2_valid", evt_valid, 1);
        check("tap_press_key",  evt_key,   2);
        check("tap_press_type", evt_type,  T_PRESS);
        @(negedge clk);
        key_db = 4'b0000;
        expect_evt(2'd2, T_REL, "tap_rel", waited);
        expect_quiet(12, "tap_no_long");
        check("tap_overflow", overflow, 0);

        // Long press on key 1 held 20 cycles: press, exactly one long, release
        key_db = 4'b0010;
        expect_evt(2'd1, T_PRESS, "long_press", waited);
        expect_evt(2'd1, T_LONG,  "long_long",  waited);
        repeat (9) @(negedge clk);
        key_db = 4'b0000;
        expect_evt(2'd1, T_REL, "long_rel", waited);
        expect_quiet(12, "long_no_extra");

        // Reset mid-operation with events queued, key 0 held through reset
        evt_ready = 1'b0;
        key_db    = 4'b0011;
        repeat (4) @(negedge clk);
        check("mid_queued_valid", evt_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid",    evt_valid, 0);
        check("mid_rst_overflow", overflow,  0);
        key_db = 4'b0001;
        @(negedge clk);
        rst       = 1'b0;
        evt_ready = 1'b1;
        expect_evt(2'd0, T_PRESS, "mid_after_rst", waited);
        expect_quiet(6, "mid_single_event");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
